alu_rs: RTL and testbench

- Reservation station that feeds the combinational ALU in the Tomasulo core. It is the initiator side of the ALU operand interface.
- Accepts decoded ALU-class instructions from issue and holds them until both operands are known. Snoops the ALU and LSB broadcast buses for missing operands.
- Dispatches one ready entry per cycle as registered {rs1, rs2, op, robid}. op=0 on that interface means idle.

---
 rtl/alu_rs.sv | 134 +++++++++++++
 tb/tb_alu_rs.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs: reservation station that holds ALU ops until both operands resolve
// and dispatches the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int RS_SIZE  = 8,
  parameter int RS_ADDR  = 3,
  parameter int ROB_ADDR = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                clear_in,
  input  logic                issue_valid,
  input  logic [5:0]          issue_op,
  input  logic [31:0]         issue_vj,
  input  logic [ROB_ADDR-1:0] issue_qj,
  input  logic                issue_has_qj,
  input  logic [31:0]         issue_vk,
  input  logic [ROB_ADDR-1:0] issue_qk,
  input  logic                issue_has_qk,
  input  logic [ROB_ADDR-1:0] issue_robid,
  output logic                full,
  input  logic                cdb_alu_valid,
  input  logic [ROB_ADDR-1:0] cdb_alu_robid,
  input  logic [31:0]         cdb_alu_result,
  input  logic                cdb_lsb_valid,
  input  logic [ROB_ADDR-1:0] cdb_lsb_robid,
  input  logic [31:0]         cdb_lsb_result,
  output logic [31:0]         alu_rs1,
  output logic [31:0]         alu_rs2,
  output logic [5:0]          alu_op,
  output logic [ROB_ADDR-1:0] alu_robid
);
  typedef struct packed {
    logic                busy;
    logic [5:0]          op;
    logic [31:0]         vj;
    logic [ROB_ADDR-1:0] qj;
    logic                has_qj;
    logic [31:0]         vk;
    logic [ROB_ADDR-1:0] qk;
    logic                has_qk;
    logic [ROB_ADDR-1:0] robid;
  } ent_t;

  ent_t                ent_q [RS_SIZE];
  ent_t                ent_d [RS_SIZE];
  logic [31:0]         rs1_q, rs1_d, rs2_q, rs2_d;
  logic [5:0]          op_q, op_d;
  logic [ROB_ADDR-1:0] robid_q, robid_d;
  logic                dsp_hit, free_hit;
  logic [RS_ADDR-1:0]  dsp_idx, free_idx;
  logic [32:0]         sj, sk;

  // Returns {still_pending, value}; the ALU bus takes precedence over the LSB bus.
  function automatic logic [32:0] snoop(input logic has, input logic [ROB_ADDR-1:0] q,
                                        input logic [31:0] v);
    if (has && cdb_alu_valid && cdb_alu_robid == q) return {1'b0, cdb_alu_result};
    if (has && cdb_lsb_valid && cdb_lsb_robid == q) return {1'b0, cdb_lsb_result};
    return {has, v};
  endfunction

  always_comb begin
    ent_d    = ent_q;
    op_d     = '0;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    robid_d  = robid_q;
    dsp_hit  = 1'b0;
    dsp_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    sj       = snoop(issue_has_qj, issue_qj, issue_vj);
    sk       = snoop(issue_has_qk, issue_qk, issue_vk);
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ent_q[i].busy && !ent_q[i].has_qj && !ent_q[i].has_qk) begin
        dsp_hit = 1'b1;
        dsp_idx = RS_ADDR'(i);
      end
      if (!ent_q[i].busy) begin
        free_hit = 1'b1;
        free_idx = RS_ADDR'(i);
      end
    end
    if (rdy_in && clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        {ent_d[i].has_qj, ent_d[i].vj} = snoop(ent_q[i].has_qj, ent_q[i].qj, ent_q[i].vj);
        {ent_d[i].has_qk, ent_d[i].vk} = snoop(ent_q[i].has_qk, ent_q[i].qk, ent_q[i].vk);
      end
      if (dsp_hit) begin
        op_d                 = ent_q[dsp_idx].op;
        rs1_d                = ent_q[dsp_idx].vj;
        rs2_d                = ent_q[dsp_idx].vk;
        robid_d              = ent_q[dsp_idx].robid;
        ent_d[dsp_idx].busy  = 1'b0;
      end
      // free_idx comes from cycle-start occupancy, so it never aliases the dispatched slot
      if (issue_valid && free_hit) begin
        ent_d[free_idx].busy   = 1'b1;
        ent_d[free_idx].op     = issue_op;
        ent_d[free_idx].qj     = issue_qj;
        ent_d[free_idx].qk     = issue_qk;
        ent_d[free_idx].robid  = issue_robid;
        ent_d[free_idx].has_qj = sj[32];
        ent_d[free_idx].vj     = sj[31:0];
        ent_d[free_idx].has_qk = sk[32];
        ent_d[free_idx].vk     = sk[31:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      robid_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      robid_q <= robid_d;
    end
  end

  assign full      = !free_hit;
  assign alu_op    = op_q;
  assign alu_rs1   = rs1_q;
  assign alu_rs2   = rs2_q;
  assign alu_robid = robid_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for the ALU reservation station.
module tb_alu_rs;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, clear_in, issue_valid, issue_has_qj, issue_has_qk, full;
  logic [5:0]  issue_op, alu_op;
  logic [31:0] issue_vj, issue_vk, cdb_alu_result, cdb_lsb_result, alu_rs1, alu_rs2;
  logic [3:0]  issue_qj, issue_qk, issue_robid, cdb_alu_robid, cdb_lsb_robid, alu_robid;
  logic        cdb_alu_valid, cdb_lsb_valid;
  int          checks = 0;
  int          errors = 0;

  alu_rs dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_qj(issue_qj),
    .issue_has_qj(issue_has_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
    .issue_has_qk(issue_has_qk), .issue_robid(issue_robid), .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_robid(cdb_alu_robid), .cdb_alu_result(cdb_alu_result),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_robid(cdb_lsb_robid), .cdb_lsb_result(cdb_lsb_result),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_robid(alu_robid)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic hqj,
                       input logic [3:0] qj, input logic [31:0] vk, input logic [3:0] robid);
    issue_valid  = 1'b1;
    issue_op     = op;
    issue_vj     = vj;
    issue_has_qj = hqj;
    issue_qj     = qj;
    issue_vk     = vk;
    issue_has_qk = 1'b0;
    issue_qk     = '0;
    issue_robid  = robid;
  endtask

  task automatic dispatch_chk(input string tag, input logic [5:0] op, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [3:0] robid);
    chk({tag, "_op"}, 64'(alu_op), 64'(op));
    chk({tag, "_rs1"}, 64'(alu_rs1), 64'(rs1));
    chk({tag, "_rs2"}, 64'(alu_rs2), 64'(rs2));
    chk({tag, "_robid"}, 64'(alu_robid), 64'(robid));
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_vj = '0; issue_qj = '0; issue_has_qj = 1'b0;
    issue_vk = '0; issue_qk = '0; issue_has_qk = 1'b0; issue_robid = '0;
    cdb_alu_valid = 1'b0; cdb_alu_robid = '0; cdb_alu_result = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_robid = '0; cdb_lsb_result = '0;
    tick(); tick();
    rst_n_in = 1'b1;
    dispatch_chk("reset", 6'd0, 32'd0, 32'd0, 4'd0);
    chk("reset_full", 64'(full), 64'd0);

    // ready issue
    issue(6'd1, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
    tick();
    issue_valid = 1'b0;
    chk("ready_insert_op", 64'(alu_op), 64'd0);
    tick();
    dispatch_chk("ready", 6'd1, 32'd5, 32'd7, 4'd3);
    tick();
    chk("ready_pulse_op", 64'(alu_op), 64'd0);
    chk("ready_hold_rs1", 64'(alu_rs1), 64'd5);

    // dependency wakeup through the LSB bus
    issue(6'd2, 32'd0, 1'b1, 4'd2, 32'd1, 4'd4);
    tick();
    issue_valid = 1'b0;
    chk("dep_wait0", 64'(alu_op), 64'd0);
    tick();
    chk("dep_wait1", 64'(alu_op), 64'd0);
    cdb_lsb_valid = 1'b1; cdb_lsb_robid = 4'd2; cdb_lsb_result = 32'd10;
    tick();
    cdb_lsb_valid = 1'b0;
    chk("dep_wake_edge", 64'(alu_op), 64'd0);
    tick();
    dispatch_chk("dep", 6'd2, 32'd10, 32'd1, 4'd4);
    tick();
    chk("dep_after", 64'(alu_op), 64'd0);

    // same-cycle bypass from the ALU bus
    issue(6'd1, 32'd0, 1'b1, 4'd6, 32'd3, 4'd5);
    cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd6; cdb_alu_result = 32'h8000_0000;
    tick();
    issue_valid = 1'b0; cdb_alu_valid = 1'b0;
    chk("byp_insert_op", 64'(alu_op), 64'd0);
    tick();
    dispatch_chk("byp", 6'd1, 32'h8000_0000, 32'd3, 4'd5);
    tick();

    // fill, overflow drop, in-order drain
    for (int i = 0; i < 8; i++) begin
      issue(6'd3, 32'd0, 1'b1, 4'd9, 32'(i), 4'(i));
      tick();
    end
    issue_valid = 1'b0;
    chk("fill_full", 64'(full), 64'd1);
    issue(6'd4, 32'd1, 1'b0, 4'd0, 32'd99, 4'd15);
    tick();
    issue_valid = 1'b0;
    chk("over_full", 64'(full), 64'd1);
    chk("over_op", 64'(alu_op), 64'd0);
    cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd9; cdb_alu_result = 32'h11;
    tick();
    cdb_alu_valid = 1'b0;
    chk("drain_wake_op", 64'(alu_op), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      dispatch_chk($sformatf("drain%0d", i), 6'd3, 32'h11, 32'(i), 4'(i));
      chk($sformatf("drain%0d_full", i), 64'(full), 64'd0);
    end
    tick();
    chk("drain_end_op", 64'(alu_op), 64'd0);
    chk("drain_end_full", 64'(full), 64'd0);

    // flush with three ready entries and a concurrent issue
    for (int i = 0; i < 3; i++) begin
      issue(6'd5, 32'd0, 1'b1, 4'd12, 32'd0, 4'(i));
      tick();
    end
    issue_valid = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd12; cdb_alu_result = 32'd1;
    tick();
    cdb_alu_valid = 1'b0;
    clear_in = 1'b1;
    issue(6'd1, 32'd2, 1'b0, 4'd0, 32'd2, 4'd7);
    tick();
    clear_in = 1'b0; issue_valid = 1'b0;
    chk("flush_op", 64'(alu_op), 64'd0);
    chk("flush_full", 64'(full), 64'd0);
    tick();
    chk("flush_after1", 64'(alu_op), 64'd0);
    tick();
    chk("flush_after2", 64'(alu_op), 64'd0);

    // pause holds the ready entry
    issue(6'd1, 32'h21, 1'b0, 4'd0, 32'd2, 4'd2);
    tick();
    issue_valid = 1'b0;
    rdy_in = 1'b0;
    tick();
    chk("pause0", 64'(alu_op), 64'd0);
    tick();
    chk("pause1", 64'(alu_op), 64'd0);
    rdy_in = 1'b1;
    tick();
    dispatch_chk("resume", 6'd1, 32'h21, 32'd2, 4'd2);
    tick();
    chk("resume_after", 64'(alu_op), 64'd0);

    // asynchronous reset mid-stream clears dispatch outputs and pending entries
    issue(6'd6, 32'd0, 1'b1, 4'd13, 32'd0, 4'd8);
    tick();
    issue(6'd5, 32'h33, 1'b0, 4'd0, 32'd4, 4'd6);
    tick();
    issue_valid = 1'b0;
    tick();
    dispatch_chk("pre_rst", 6'd5, 32'h33, 32'd4, 4'd6);
    rst_n_in = 1'b0;
    #1;
    dispatch_chk("async_rst", 6'd0, 32'd0, 32'd0, 4'd0);
    chk("async_rst_full", 64'(full), 64'd0);
    tick();
    rst_n_in = 1'b1;
    cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd13; cdb_alu_result = 32'd7;
    tick();
    cdb_alu_valid = 1'b0;
    tick();
    chk("post_rst_op", 64'(alu_op), 64'd0);
    tick();
    chk("post_rst_op2", 64'(alu_op), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
